// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions for the Beta core: payload layouts per stage
// boundary, bubble encodings and the stage-register occupancy states.
package pipe_pkg;

  localparam int unsigned IFID_W        = 67;
  localparam int unsigned IFID_PC_LSB   = 35;
  localparam int unsigned IFID_RA2SEL   = 34;
  localparam int unsigned IFID_ASEL     = 33;
  localparam int unsigned IFID_BSEL     = 32;
  localparam int unsigned IFID_SXTC_LSB = 0;

  localparam int unsigned IDEX_W      = 128;
  localparam int unsigned IDEX_PC_LSB = 96;
  localparam int unsigned IDEX_A_LSB  = 64;
  localparam int unsigned IDEX_B_LSB  = 32;
  localparam int unsigned IDEX_IR_LSB = 0;

  localparam int unsigned EXMEM_W      = 128;
  localparam int unsigned EXMEM_PC_LSB = 96;
  localparam int unsigned EXMEM_Y_LSB  = 64;
  localparam int unsigned EXMEM_D_LSB  = 32;
  localparam int unsigned EXMEM_IR_LSB = 0;

  localparam int unsigned MEMWB_W      = 96;
  localparam int unsigned MEMWB_PC_LSB = 64;
  localparam int unsigned MEMWB_Y_LSB  = 32;
  localparam int unsigned MEMWB_IR_LSB = 0;

  // ADD(R31, R31, R31): architectural no-op used as the bubble instruction
  localparam logic [31:0] BETA_NOP = 32'h83FF_F800;

  localparam logic [IFID_W-1:0]  IFID_NOP  = '0;
  localparam logic [IDEX_W-1:0]  IDEX_NOP  = {96'h0, BETA_NOP};
  localparam logic [EXMEM_W-1:0] EXMEM_NOP = {96'h0, BETA_NOP};
  localparam logic [MEMWB_W-1:0] MEMWB_NOP = {64'h0, BETA_NOP};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  function automatic logic [IFID_W-1:0] ifid_pack(input logic [31:0] pc,
                                                  input logic        ra2sel,
                                                  input logic        asel,
                                                  input logic        bsel,
                                                  input logic [31:0] sxtc);
    return {pc, ra2sel, asel, bsel, sxtc};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single overflow entry with valid flag; catches the payload accepted while the
// downstream register is stalled.
module pipe_skid_buf #(
  parameter int unsigned DATA_W = 67
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i || pop_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that decouples in_ready from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = IFID_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] NOP_VAL   = '0,
  parameter int unsigned       SKID      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] main_q, main_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occ_q, occ_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q      <= RESET_VAL;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;

  if (SKID == 0) begin : g_single
    logic in_ready_c;

    // Ready whenever the register is empty or being drained this cycle
    assign in_ready_c = ~out_valid_q | out_ready;
    assign in_ready   = in_ready_c;

    always_comb begin
      main_d      = main_q;
      out_valid_d = out_valid_q;
      if (flush) begin
        main_d      = NOP_VAL;
        out_valid_d = 1'b0;
      end else if (in_ready_c) begin
        out_valid_d = in_valid;
        if (in_valid) main_d = in_data;
      end
      occ_d = {1'b0, out_valid_d};
    end

    a_occ_single : assert property (@(posedge clk) disable iff (!rst_n) occ_q <= 2'd1);

  end else begin : g_skid
    occ_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              accept_c, drain_c;
    logic              skid_load_c, skid_pop_c;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;

    assign accept_c = in_valid & in_ready_q;
    assign drain_c  = out_valid_q & out_ready;
    assign in_ready = in_ready_q;

    pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .load_i  (skid_load_c),
      .pop_i   (skid_pop_c),
      .data_i  (in_data),
      .data_o  (skid_data),
      .valid_o (skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= OCC_EMPTY;
        in_ready_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
      end
    end

    // Occupancy FSM; the main register always holds the oldest entry
    always_comb begin
      state_d     = state_q;
      main_d      = main_q;
      skid_load_c = 1'b0;
      skid_pop_c  = 1'b0;
      if (flush) begin
        state_d = OCC_EMPTY;
        main_d  = NOP_VAL;
      end else begin
        unique case (state_q)
          OCC_EMPTY: begin
            if (accept_c) begin
              main_d  = in_data;
              state_d = OCC_MAIN;
            end
          end
          OCC_MAIN: begin
            if (accept_c && drain_c) begin
              main_d = in_data;
            end else if (accept_c) begin
              skid_load_c = 1'b1;
              state_d     = OCC_FULL;
            end else if (drain_c) begin
              state_d = OCC_EMPTY;
            end
          end
          OCC_FULL: begin
            if (drain_c) begin
              main_d     = skid_data;
              skid_pop_c = 1'b1;
              state_d    = OCC_MAIN;
            end
          end
          default: state_d = OCC_EMPTY;
        endcase
      end
      out_valid_d = (state_d != OCC_EMPTY);
      in_ready_d  = (state_d != OCC_FULL);
      occ_d       = 2'(state_d);
    end

    a_occ_skid  : assert property (@(posedge clk) disable iff (!rst_n) occ_q <= 2'd2);
    a_skid_full : assert property (@(posedge clk) disable iff (!rst_n)
                                   (state_q == OCC_FULL) == skid_valid);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Checks a skid and a single-register stage side by side against queue models,
// with directed scenarios pinned by literal expectations plus a random soak.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned W = IFID_W;
  localparam logic [W-1:0] RV = 67'h1_0000_1234;
  localparam logic [W-1:0] NV = 67'h2_83FF_F800;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         rdy1, ov1, rdy0, ov0;
  logic [W-1:0] od1, od0;
  logic [1:0]   occ1, occ0;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] last1, last0;
  logic         mrdy1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV), .NOP_VAL(NV), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV), .NOP_VAL(NV), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ0));

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    last1 = RV;
    last0 = RV;
    mrdy1 = 1'b0;
  endtask

  // Transfers seen at one rising edge, from the inputs held across it
  task automatic model_update();
    logic acc, drn;
    if (flush) begin
      q1.delete(); q0.delete();
      last1 = NV;  last0 = NV;
      mrdy1 = 1'b1;
    end else begin
      acc = in_valid && mrdy1;
      drn = (q1.size() > 0) && out_ready;
      if (drn) last1 = q1.pop_front();
      if (acc) q1.push_back(in_data);
      mrdy1 = (q1.size() < 2);
      acc = in_valid && ((q0.size() == 0) || out_ready);
      drn = (q0.size() > 0) && out_ready;
      if (drn) last0 = q0.pop_front();
      if (acc) q0.push_back(in_data);
    end
  endtask

  task automatic check_all();
    check("skid_valid", W'(ov1), W'(q1.size() > 0));
    check("skid_data",  od1, (q1.size() > 0) ? q1[0] : last1);
    check("skid_occ",   W'(occ1), W'(q1.size()));
    check("skid_ready", W'(rdy1), W'(mrdy1));
    check("reg_valid",  W'(ov0), W'(q0.size() > 0));
    check("reg_data",   od0, (q0.size() > 0) ? q0[0] : last0);
    check("reg_occ",    W'(occ0), W'(q0.size()));
    check("reg_ready",  W'(rdy0), W'((q0.size() == 0) || out_ready));
  endtask

  task automatic step(input logic iv, input logic [W-1:0] d, input logic orr, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    #1;
    check_all();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_data_lit", od1, RV);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("rel_ready_lit", W'(rdy1), W'(1'b1));

    // Streaming, one cycle latency, no back-pressure
    for (int k = 0; k < 10; k++) begin
      step(1'b1, W'(k), 1'b1, 1'b0);
      check("stream_lit", od1, W'(k));
      check("stream_rdy_lit", W'(rdy1), W'(1'b1));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Stall into the skid entry, then release
    step(1'b1, W'(8'hA), 1'b0, 1'b0);
    check("stall_occ1_lit", W'(occ1), W'(2'd1));
    step(1'b1, W'(8'hB), 1'b0, 1'b0);
    check("stall_occ2_lit", W'(occ1), W'(2'd2));
    check("stall_rdy_lit", W'(rdy1), W'(1'b0));
    step(1'b1, W'(8'hC), 1'b0, 1'b0);
    check("stall_hold_lit", od1, W'(8'hA));
    step(1'b1, W'(8'hC), 1'b1, 1'b0);
    check("rel_b_lit", od1, W'(8'hB));
    step(1'b1, W'(8'hC), 1'b1, 1'b0);
    check("rel_c_lit", od1, W'(8'hC));
    step(1'b0, '0, 1'b1, 1'b0);
    check("rel_empty_lit", W'(occ1), W'(2'd0));

    // Single register: in_ready drops in the same cycle as the stall
    step(1'b1, W'(8'h44), 1'b1, 1'b0);
    check("reg_load_lit", od0, W'(8'h44));
    in_valid = 1'b1; in_data = W'(8'h45); out_ready = 1'b0;
    #1;
    check("reg_stall_rdy_lit", W'(rdy0), W'(1'b0));
    @(posedge clk);
    model_update();
    #1;
    check_all();
    check("reg_stall_hold_lit", od0, W'(8'h44));
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, payload presented with the flush is discarded
    step(1'b1, W'(8'h01), 1'b0, 1'b0);
    step(1'b1, W'(8'h02), 1'b0, 1'b0);
    check("fill_full_lit", W'(occ1), W'(2'd2));
    step(1'b1, W'(8'h55), 1'b0, 1'b1);
    check("flush_valid_lit", W'(ov1), W'(1'b0));
    check("flush_data_lit", od1, NV);
    check("flush_occ_lit", W'(occ1), W'(2'd0));
    check("flush_rdy_lit", W'(rdy1), W'(1'b1));
    check("flush_reg_data_lit", od0, NV);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_gone_lit", W'(ov1), W'(1'b0));

    // Asynchronous reset in the middle of a stall
    step(1'b1, W'(8'h71), 1'b0, 1'b0);
    step(1'b1, W'(8'h72), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_data_lit", od1, RV);
    check("async_rst_occ_lit", W'(occ1), W'(2'd0));
    #2;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("rst_rel_rdy_lit", W'(rdy1), W'(1'b1));

    // Random soak
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), W'({$urandom, $urandom, $urandom}),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
